// File: rtl/sim_run_monitor.sv
// sim_run_monitor: console receiver and run-control watchdog for simulation
// and bring-up harnesses. Decodes 8N1 frames from the DUT UART line into a
// first-word-fall-through FIFO and ends the run on END_BYTE or a cycle budget.
//
// state | meaning
// IDLE  | line idle; waits for the line to go high, then for a falling start edge
// START | half-bit delay, then confirm the start bit is still low
// DATA  | sample eight data bits at mid-bit, LSB first
// STOP  | sample the stop bit; good bytes go to the FIFO
module sim_run_monitor #(
    parameter int         CLK_DIV    = 16,
    parameter int         MAX_CYCLES = 1000000,
    parameter int         CNT_W      = 32,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] END_BYTE   = 8'h04
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          uart_line_i,
    output logic                          rx_valid_o,
    output logic [7:0]                    rx_data_o,
    input  logic                          rx_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          overflow_o,
    output logic                          frame_err_o,
    output logic [CNT_W-1:0]              cycle_o,
    output logic                          done_o,
    output logic                          timeout_o,
    output logic                          finish_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(CLK_DIV);
    localparam logic [TW-1:0]    HALF_LOAD = TW'(CLK_DIV / 2 - 1);
    localparam logic [TW-1:0]    FULL_LOAD = TW'(CLK_DIV - 1);
    localparam logic [AW:0]      DEPTH     = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_CYCLES);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [1:0]    sync_q;
    logic          rxs;
    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          armed;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    logic          stop_tick;
    logic          push;
    logic          pop;
    logic          full;
    logic          done_set;

    assign rxs       = sync_q[1];
    assign stop_tick = (state == STOP) && (timer == '0);
    assign push      = stop_tick && rxs;
    assign done_set  = push && (shreg == END_BYTE) && !timeout_o;

    assign fifo_count_o = wr_ptr - rd_ptr;
    assign rx_valid_o   = (wr_ptr != rd_ptr);
    assign full         = (fifo_count_o == DEPTH);
    assign pop          = rx_valid_o && rx_ready_i;
    assign rx_data_o    = rx_valid_o ? mem[rd_ptr[AW-1:0]] : 8'h00;
    assign finish_o     = done_o | timeout_o;

    // Two-flop synchroniser for the asynchronous UART line, idling high.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], uart_line_i};
    end

    // Receiver FSM with the sticky frame-error and done flags.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            timer       <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            armed       <= 1'b1;
            frame_err_o <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rxs) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        state <= START;
                        timer <= HALF_LOAD;
                    end
                end
                START: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else if (rxs) begin
                        state <= IDLE;
                    end else begin
                        state   <= DATA;
                        timer   <= FULL_LOAD;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else begin
                        shreg   <= {rxs, shreg[7:1]};
                        timer   <= FULL_LOAD;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end
                end
                STOP: begin
                    if (timer != '0) begin
                        timer <= timer - 1'b1;
                    end else begin
                        state <= IDLE;
                        // A low stop bit means the line is still low; require
                        // it to return high before the next start is accepted.
                        armed <= rxs;
                        if (!rxs)     frame_err_o <= 1'b1;
                        if (done_set) done_o      <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Receive FIFO: a push into a full FIFO survives only alongside a pop.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_o <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push && (!full || pop)) begin
                mem[wr_ptr[AW-1:0]] <= shreg;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (push && full && !pop) overflow_o <= 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Cycle counter and watchdog; both freeze once the run has finished.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cycle_o   <= '0;
            timeout_o <= 1'b0;
        end else if (!finish_o) begin
            cycle_o <= cycle_o + CNT_W'(1);
            if ((cycle_o + CNT_W'(1) == MAX_CNT) && !done_set) timeout_o <= 1'b1;
        end
    end

endmodule

// File: doc/sim_run_monitor.md
# sim_run_monitor

Parametrised run-control and console monitor for nano-z80 simulation and FPGA bring-up harnesses. It watches the DUT's UART transmit line and decodes 8N1 frames into a small FIFO for host or bench consumption. It also counts clock cycles and ends the run on either a configurable end-of-test byte or a cycle-budget timeout. It replaces the fixed hard-coded time limit with a parametrised watchdog, a decoded console stream, and pass/timeout status.

## Interface
- CLK_DIV, 16: clocks per UART bit; must be even and ≥ 4.
- MAX_CYCLES, 1000000: cycle budget before timeout; must be ≥ 1.
- CNT_W, 32: cycle counter width; must satisfy 2^CNT_W > MAX_CYCLES.
- FIFO_DEPTH, 16: receive FIFO entries; power of 2, ≥ 2.
- END_BYTE, 8'h04: received byte that signals test completion.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-low.
- uart_line_i  in  1  DUT UART TX line; idle high; asynchronous to clk_i.
- rx_valid_o  out  1  FIFO head valid.
- rx_data_o  out  8  FIFO head byte.
- rx_ready_i  in  1  consumer pops the head when rx_valid_o && rx_ready_i.
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow_o  out  1  sticky; a good byte was dropped because the FIFO was full.
- frame_err_o  out  1  sticky; a stop bit was sampled low.
- cycle_o  out  CNT_W  cycles elapsed since reset release.
- done_o  out  1  sticky; END_BYTE received with a valid stop bit.
- timeout_o  out  1  sticky; cycle budget exhausted before done.
- finish_o  out  1  done_o | timeout_o.

## Operation
- Input path: uart_line_i passes through a 2-flop synchroniser. Both flops reset to 1. All receiver logic uses the synchronised value `rxs`.
- Receiver FSM states: IDLE, START, DATA, STOP.
  - IDLE: on `rxs` = 0, go to START and load the bit timer with CLK_DIV/2 − 1.
  - START: when the timer expires, sample `rxs`. If it is 1, treat it as a glitch and return to IDLE with no flag. If it is 0, go to DATA with the timer at CLK_DIV − 1 and the bit index at 0.
  - DATA: sample a bit each time the timer expires, LSB first, shifting into the shift register. After bit 7, go to STOP.
  - STOP: when the timer expires, sample `rxs`.
    - If it is 1, the byte is good: push it to the FIFO, and if byte == END_BYTE set done_o.
    - If it is 0, set frame_err_o and discard the byte.
    - Go to IDLE either way. The FSM waits in IDLE for `rxs` = 1 before it can detect the next start bit (no break re-trigger).
- FIFO: circular buffer with pointers one bit wider than the address. It is first-word-fall-through: rx_data_o is the head entry while rx_valid_o = 1.
  - When not full, a push is accepted.
  - When full, a push is accepted only if a pop occurs in the same cycle. Otherwise the byte is dropped and overflow_o is set.
  - Simultaneous push and pop when empty: the pop is ignored (rx_valid_o = 0) and the push is accepted.
  - END_BYTE is stored in the FIFO like any other good byte.
- Cycle counter: starts at 0 and increments by 1 each clock while finish_o = 0. It never wraps.
- Watchdog: timeout_o is set on the edge where cycle_o becomes MAX_CYCLES, provided done_o is not set on the same edge. If both would set together, done_o wins and timeout_o stays 0.
- After finish_o goes high:
  - cycle_o freezes.
  - The receiver and FIFO keep operating.
  - done_o and timeout_o are mutually exclusive, and both hold until reset.
- Reset: asserting rst_i at any time, including mid-frame, immediately returns every state element to its reset value. A partially received byte is lost.

## Timing
- Reset values: rx_valid_o = 0, rx_data_o = 0, fifo_count_o = 0, overflow_o = 0, frame_err_o = 0, cycle_o = 0, done_o = 0, timeout_o = 0, finish_o = 0. The FSM is in IDLE and both synchroniser flops hold 1.
- Edge timing: let t0 be the first edge where `rxs` = 0, which is 2 edges after uart_line_i falls.
  - Start bit is sampled at t0 + CLK_DIV/2.
  - Data bit i is sampled at t0 + CLK_DIV/2 + (i+1)·CLK_DIV.
  - Stop bit is sampled at t0 + CLK_DIV/2 + 9·CLK_DIV.
- On the stop-sample edge, the FIFO write, the frame_err_o update and the done_o update are all registered.
- rx_valid_o, the fifo_count_o change and finish_o become visible in the cycle after that edge.
- Pop: fifo_count_o and the head entry update on the same edge where rx_valid_o && rx_ready_i is high.
- Glitch rejection: a low pulse on `rxs` shorter than CLK_DIV/2 cycles is ignored.

## Test plan
- Single byte, CLK_DIV=16, rx_ready_i=1: send 8'h41 → rx_valid_o pulses for 1 cycle with rx_data_o = 8'h41 at t0+153, and frame_err_o = 0.
- Stop bit forced low, data 8'h55 → frame_err_o = 1 from t0+153, fifo_count_o stays 0, rx_valid_o never asserts.
- rx_ready_i=0, FIFO_DEPTH=16: send bytes 0..16 → fifo_count_o = 16 and overflow_o = 1. Then raise rx_ready_i → bytes 0..15 pop in order; byte 16 is absent.
- Send 8'h31 then 8'h04 → both bytes are queued, done_o = finish_o = 1, cycle_o frozen, timeout_o stays 0 beyond MAX_CYCLES.
- MAX_CYCLES=500 with the line held idle → timeout_o and finish_o rise when cycle_o reaches 500; cycle_o holds 500.
- Glitch and reset: a 3-cycle low pulse on the line produces no byte and no flag. rst_i asserted low during DATA bit 4 → all outputs return to reset values, and the next clean frame 8'h5A decodes correctly.
